// File: rtl/pixel_pkg.sv
// Pixel and 3x3 window types shared by window_sequencer and median_filter,
// plus the default frame geometry and the sequencer state encoding.
package pixel_pkg;

  localparam int IMG_W = 640;
  localparam int IMG_H = 480;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] grn;
    logic [7:0] blu;
  } pixel_t;

  // chunk[i][j]: i = row (0 = top), j = col (0 = left), [1][1] = centre
  typedef pixel_t [2:0][2:0] chunk_t;

  // One vertical slice of a window: rows r-1, r, r+1 at a single column.
  typedef struct packed {
    pixel_t top;
    pixel_t mid;
    pixel_t bot;
  } column_t;

  typedef enum logic [1:0] {
    FILL,
    RUN,
    EDGE,
    FLUSH
  } win_state_e;

endpackage

// File: rtl/axis_if.sv
// Minimal valid/ready stream: one data_t beat transfers on a cycle with vld && rdy.
interface axis_if #(
  parameter type data_t = logic [7:0]
);
  logic  vld;
  logic  rdy;
  data_t data;

  modport master (output vld, output data, input rdy);
  modport slave  (input vld, input data, output rdy);
endinterface

// File: rtl/line_buffer.sv
// One-row pixel store: read data is valid in the same cycle as addr, and a write
// lands at the clock edge, so a read and write to one column is read-before-write.
module line_buffer #(
  parameter int  DEPTH     = 640,
  parameter type DATA_TYPE = logic [23:0]
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic                     we,
  input  DATA_TYPE                 wdata,
  output DATA_TYPE                 rdata
);

  DATA_TYPE mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/window_sequencer.sv
// Raster pixel stream -> one centre-aligned 3x3 window per pixel (FILL/RUN/EDGE/FLUSH).
// Define WINDOW_ZERO_BORDER_EN for zero-valued out-of-frame taps instead of edge replication.
module window_sequencer
  import pixel_pkg::*;
#(
  parameter int IMG_W = pixel_pkg::IMG_W,
  parameter int IMG_H = pixel_pkg::IMG_H
) (
  input  logic   clk,
  input  logic   rst,
  axis_if.slave  axis_i,
  axis_if.master axis_o,
  output logic   busy,
  output logic   frame_done
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

`ifdef WINDOW_ZERO_BORDER_EN
  localparam bit ZERO_BORDER = 1'b1;
`else
  localparam bit ZERO_BORDER = 1'b0;
`endif

  function automatic pixel_t border(input pixel_t repl);
    return ZERO_BORDER ? pixel_t'('0) : repl;
  endfunction

  function automatic column_t border_col(input column_t c);
    column_t b;
    b.top = border(c.top);
    b.mid = border(c.mid);
    b.bot = border(c.bot);
    return b;
  endfunction

  function automatic chunk_t make_win(input column_t l, input column_t c, input column_t r);
    chunk_t w;
    w[0][0] = l.top; w[0][1] = c.top; w[0][2] = r.top;
    w[1][0] = l.mid; w[1][1] = c.mid; w[1][2] = r.mid;
    w[2][0] = l.bot; w[2][1] = c.bot; w[2][2] = r.bot;
    return w;
  endfunction

  win_state_e       state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  column_t          c1_q, c1_d;
  column_t          c2_q, c2_d;
  logic             out_vld_q, out_vld_d;
  chunk_t           out_dat_q, out_dat_d;
  logic             out_last_q, out_last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             in_rdy;
  logic             in_hs;
  logic             out_free;
  logic [COL_W-1:0] lb_addr;
  pixel_t           lb_a_rd;
  pixel_t           lb_b_rd;
  column_t          in_col;
  column_t          flush_col;

  // lb_a holds the most recently completed row, lb_b the row above it; each
  // accepted pixel pushes lb_a's old column value down into lb_b.
  line_buffer #(.DEPTH(IMG_W), .DATA_TYPE(pixel_t)) u_lb_a (
    .clk   (clk),
    .addr  (lb_addr),
    .we    (in_hs),
    .wdata (axis_i.data),
    .rdata (lb_a_rd)
  );

  line_buffer #(.DEPTH(IMG_W), .DATA_TYPE(pixel_t)) u_lb_b (
    .clk   (clk),
    .addr  (lb_addr),
    .we    (in_hs),
    .wdata (lb_a_rd),
    .rdata (lb_b_rd)
  );

  assign out_free = !out_vld_q || axis_o.rdy;
  assign in_rdy   = !rst && ((state_q == FILL) || (state_q == RUN)) && out_free;
  assign in_hs    = axis_i.vld && in_rdy;

  always_comb begin
    in_col.top = (row_q == ROW_ONE) ? border(lb_a_rd) : lb_b_rd;
    in_col.mid = lb_a_rd;
    in_col.bot = axis_i.data;
    flush_col.top = lb_b_rd;
    flush_col.mid = lb_a_rd;
    flush_col.bot = border(lb_a_rd);
  end

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    c1_d       = c1_q;
    c2_d       = c2_q;
    out_vld_d  = out_vld_q && !axis_o.rdy;
    out_dat_d  = out_dat_q;
    out_last_d = out_last_q;
    busy_d     = busy_q || in_hs;
    done_d     = 1'b0;
    lb_addr    = col_q;

    case (state_q)
      FILL: begin
        if (in_hs) begin
          if (col_q == COL_LAST) begin
            col_d   = '0;
            row_d   = ROW_ONE;
            state_d = RUN;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end

      RUN: begin
        if (in_hs) begin
          if (col_q != '0) begin
            out_vld_d = 1'b1;
            out_dat_d = make_win((col_q == COL_ONE) ? border_col(c1_q) : c2_q, c1_q, in_col);
          end
          c2_d = c1_q;
          c1_d = in_col;
          if (col_q == COL_LAST) begin
            col_d   = '0;
            row_d   = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            state_d = EDGE;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end

      EDGE: begin
        // Pre-read column 0 so a following FLUSH starts with its centre column loaded.
        lb_addr = '0;
        if (out_free) begin
          out_vld_d = 1'b1;
          out_dat_d = make_win(c2_q, c1_q, border_col(c1_q));
          c1_d      = flush_col;
          state_d   = (row_q == '0) ? FLUSH : RUN;
        end
      end

      FLUSH: begin
        lb_addr = (col_q == COL_LAST) ? COL_LAST : col_q + 1'b1;
        if (out_last_q) begin
          if (axis_o.rdy) begin
            out_last_d = 1'b0;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            state_d    = FILL;
          end
        end else if (out_free) begin
          out_vld_d = 1'b1;
          out_dat_d = make_win((col_q == '0) ? border_col(c1_q) : c2_q, c1_q,
                               (col_q == COL_LAST) ? border_col(c1_q) : flush_col);
          c2_d = c1_q;
          c1_d = flush_col;
          if (col_q == COL_LAST) begin
            col_d      = '0;
            out_last_d = 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end

      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      col_q      <= '0;
      row_q      <= '0;
      c1_q       <= '0;
      c2_q       <= '0;
      out_vld_q  <= 1'b0;
      out_dat_q  <= '0;
      out_last_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      c1_q       <= c1_d;
      c2_q       <= c2_d;
      out_vld_q  <= out_vld_d;
      out_dat_q  <= out_dat_d;
      out_last_q <= out_last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign axis_i.rdy  = in_rdy;
  assign axis_o.vld  = out_vld_q;
  assign axis_o.data = out_dat_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;

endmodule

// File: tb/tb_window_sequencer.sv
// Directed bench for window_sequencer on a 4x3 frame where pixel (r,c) = 16*r+c.
module tb_window_sequencer;
  import pixel_pkg::*;

  localparam int W = 4;
  localparam int H = 3;
  localparam int NPIX = W * H;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  logic frame_done;

  axis_if #(.data_t(pixel_t)) in_if ();
  axis_if #(.data_t(chunk_t)) out_if ();

  window_sequencer #(.IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .axis_i     (in_if),
    .axis_o     (out_if),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               r;
    int               c;
    logic [8:0][7:0]  t;
  } vec_t;

  int     checks = 0;
  int     errors = 0;
  chunk_t got[$];
  int     done_cnt = 0;
  int     rdy_mode = 0;
  int     cyc = 0;
  bit     check_busy = 0;
  bit     exp_busy = 0;
  bit     prev_stall = 0;
  bit     prev_done = 0;
  chunk_t prev_dat;
  vec_t   vecs[$];

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_win(input string name, input chunk_t act, input chunk_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic pixel_t pix_of(input int k);
    pixel_t p;
    int v;
    v = 16 * ((k % NPIX) / W) + (k % W);
    p.red = 8'(v);
    p.grn = 8'(v);
    p.blu = 8'(v);
    return p;
  endfunction

  function automatic chunk_t model_win(input int r, input int c);
    chunk_t w;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        int rr;
        int cc;
        int v;
        rr = r + i - 1;
        cc = c + j - 1;
        v = 16 * ((rr < 0) ? 0 : (rr >= H) ? H - 1 : rr) + ((cc < 0) ? 0 : (cc >= W) ? W - 1 : cc);
`ifdef WINDOW_ZERO_BORDER_EN
        if (rr < 0 || rr >= H || cc < 0 || cc >= W) v = 0;
`endif
        w[i][j].red = 8'(v);
        w[i][j].grn = 8'(v);
        w[i][j].blu = 8'(v);
      end
    end
    return w;
  endfunction

  function automatic logic [8:0][7:0] tv(input int a0, input int a1, input int a2,
                                         input int a3, input int a4, input int a5,
                                         input int a6, input int a7, input int a8);
    logic [8:0][7:0] t;
    t[0] = 8'(a0); t[1] = 8'(a1); t[2] = 8'(a2);
    t[3] = 8'(a3); t[4] = 8'(a4); t[5] = 8'(a5);
    t[6] = 8'(a6); t[7] = 8'(a7); t[8] = 8'(a8);
    return t;
  endfunction

  // Output-side monitor: captures windows, stall stability, input blocking, pulse width, busy.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) begin
        chk_int("stall_vld_held", int'(out_if.vld), 1);
        chk_win("stall_data_held", out_if.data, prev_dat);
      end
      if (out_if.vld && !out_if.rdy) chk_int("in_rdy_while_blocked", int'(in_if.rdy), 0);
      if (frame_done) begin
        done_cnt++;
        chk_int("frame_done_width", int'(prev_done), 0);
      end
      if (check_busy) begin
        if (frame_done) exp_busy = 1'b0;
        chk_int("busy", int'(busy), int'(exp_busy));
      end
      if (out_if.vld && out_if.rdy) got.push_back(out_if.data);
      if (in_if.vld && in_if.rdy) exp_busy = 1'b1;
      prev_stall = out_if.vld && !out_if.rdy;
      prev_dat   = out_if.data;
      prev_done  = frame_done;
    end else begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end
  end

  initial begin
    out_if.rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      out_if.rdy = (rdy_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
    end
  end

  task automatic send_pixels(input int n, input bit rand_vld);
    int k;
    int guard;
    bit xfer;
    k = 0;
    guard = 0;
    while (k < n && guard < 2000) begin
      if (rand_vld && $urandom_range(1, 0) == 0) begin
        in_if.vld = 1'b0;
      end else begin
        in_if.vld  = 1'b1;
        in_if.data = pix_of(k);
      end
      @(negedge clk);
      xfer = in_if.vld && in_if.rdy;
      @(posedge clk);
      #1;
      if (xfer) k++;
      guard++;
    end
    in_if.vld = 1'b0;
    chk_int("pixels_accepted", k, n);
  endtask

  task automatic wait_done(input string name, input int target);
    int g;
    g = 0;
    while (done_cnt < target && g < 1000) begin
      @(posedge clk);
      #1;
      g++;
    end
    repeat (6) @(posedge clk);
    #1;
    chk_int({name, "_frame_done_count"}, done_cnt, target);
  endtask

  task automatic check_frame(input string name, input int first);
    for (int k = 0; k < NPIX; k++) begin
      if (first + k < got.size())
        chk_win($sformatf("%s_win_r%0d_c%0d", name, k / W, k % W), got[first + k], model_win(k / W, k % W));
    end
  endtask

  task automatic start_test(input int mode);
    rdy_mode = mode;
    got.delete();
    done_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    chunk_t e;
`ifdef WINDOW_ZERO_BORDER_EN
    vecs.push_back('{r: 0, c: 0, t: tv(0, 0, 0, 0, 0, 1, 0, 16, 17)});
    vecs.push_back('{r: 2, c: 3, t: tv(18, 19, 0, 34, 35, 0, 0, 0, 0)});
`else
    vecs.push_back('{r: 0, c: 0, t: tv(0, 0, 1, 0, 0, 1, 16, 16, 17)});
    vecs.push_back('{r: 1, c: 3, t: tv(2, 3, 3, 18, 19, 19, 34, 35, 35)});
    vecs.push_back('{r: 2, c: 0, t: tv(16, 16, 17, 32, 32, 33, 32, 32, 33)});
    vecs.push_back('{r: 0, c: 3, t: tv(2, 3, 3, 2, 3, 3, 18, 19, 19)});
    vecs.push_back('{r: 1, c: 0, t: tv(0, 0, 1, 16, 16, 17, 32, 32, 33)});
    vecs.push_back('{r: 1, c: 1, t: tv(0, 1, 2, 16, 17, 18, 32, 33, 34)});
    vecs.push_back('{r: 2, c: 3, t: tv(18, 19, 19, 34, 35, 35, 34, 35, 35)});
`endif

    in_if.vld  = 1'b0;
    in_if.data = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_int("reset_out_vld", int'(out_if.vld), 0);
    chk_win("reset_out_data", out_if.data, '0);
    chk_int("reset_in_rdy", int'(in_if.rdy), 0);
    chk_int("reset_busy", int'(busy), 0);
    chk_int("reset_frame_done", int'(frame_done), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Full-rate frame, then hand-computed windows against the same capture.
    start_test(0);
    send_pixels(NPIX, 1'b0);
    wait_done("t1", 1);
    chk_int("t1_window_count", got.size(), NPIX);
    check_frame("t1", 0);
    foreach (vecs[v]) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          e[i][j].red = vecs[v].t[i * 3 + j];
          e[i][j].grn = vecs[v].t[i * 3 + j];
          e[i][j].blu = vecs[v].t[i * 3 + j];
        end
      end
      if (vecs[v].r * W + vecs[v].c < got.size())
        chk_win($sformatf("vec_r%0d_c%0d", vecs[v].r, vecs[v].c), got[vecs[v].r * W + vecs[v].c], e);
    end

    // Output ready only one cycle in three.
    start_test(1);
    send_pixels(NPIX, 1'b0);
    wait_done("t3", 1);
    chk_int("t3_window_count", got.size(), NPIX);
    check_frame("t3", 0);

    // Bursty input with busy tracking.
    start_test(0);
    exp_busy   = 1'b0;
    check_busy = 1'b1;
    send_pixels(NPIX, 1'b1);
    wait_done("t4", 1);
    check_busy = 1'b0;
    chk_int("t4_window_count", got.size(), NPIX);
    check_frame("t4", 0);

    // Reset mid-frame after six pixels, then a clean frame.
    start_test(0);
    send_pixels(6, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_int("t5_vld_after_rst", int'(out_if.vld), 0);
    chk_win("t5_data_after_rst", out_if.data, '0);
    chk_int("t5_busy_after_rst", int'(busy), 0);
    start_test(0);
    send_pixels(NPIX, 1'b0);
    wait_done("t5", 1);
    chk_int("t5_window_count", got.size(), NPIX);
    check_frame("t5", 0);

    // Two frames back-to-back.
    start_test(0);
    send_pixels(2 * NPIX, 1'b0);
    wait_done("t6", 2);
    chk_int("t6_window_count", got.size(), 2 * NPIX);
    check_frame("t6_f0", 0);
    check_frame("t6_f1", NPIX);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation time exceeded, required completion");
    $fatal(1, "timeout");
  end

endmodule
